uart_echo_engine: RTL and testbench

Parametrised successor to the board-level UART loopback: a byte-stream echo core between an existing uart_rx (byte/valid) and uart_tx (byte/valid/busy) pair. Received bytes go through a configurable-depth FIFO and are transmitted back under a runtime-selectable mode: raw echo, uppercase fold, CR→CR LF expansion, or silent sink. Adds overflow detection, drop counting, fill-level reporting and a synchronous reset. Sits in the top level of the UART templates, replacing the inline loopback logic.

---
 rtl/uart_echo_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_echo_engine.sv | 135 +++++++++++++
 tb/tb_uart_echo_engine.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// Shared encodings for the UART echo core: transmit modes, FSM states, ASCII constants.
package uart_echo_pkg;

  localparam logic [1:0] MODE_ECHO  = 2'b00;
  localparam logic [1:0] MODE_UPPER = 2'b01;
  localparam logic [1:0] MODE_CRLF  = 2'b10;
  localparam logic [1:0] MODE_SINK  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;
  localparam logic [7:0] CASE_OFS   = 8'h20;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a registered occupancy count.
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  // Same index with differing MSB means the writer has lapped the reader.
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_echo_engine.sv
// Byte echo core between uart_rx and uart_tx: FIFO, per-mode transform, launch FSM, status.
//   state        | meaning
//   ST_IDLE      | pop head when FIFO non-empty and tx idle (sink mode just discards)
//   ST_LAUNCH    | tx_valid high for this one cycle
//   ST_WAIT_BUSY | wait for uart_tx to assert busy
//   ST_WAIT_DONE | wait for busy to drop, then send a pending LF or go idle
module uart_echo_engine
  import uart_echo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int LED_W      = 6,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  input  logic [1:0]            mode,
  input  logic                  clr_status,
  output logic [LED_W-1:0]      led,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic [CNT_W-1:0]      drop_cnt
);

  state_t            state, state_nx;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] xf_data;
  logic [DATA_W-1:0] tx_data_nx;
  logic              xf_lf;
  logic              tx_valid_nx;
  logic              pending_lf, pending_lf_nx;
  logic              full, empty;
  logic              push, pop, drop;

  assign push = rx_valid && !full;
  assign drop = rx_valid && full;
  assign pop  = (state == ST_IDLE) && !empty && !tx_busy;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (rx_data),
    .rd_data (head),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );

  // Character transforms only make sense for 8-bit bytes; wider words pass through.
  always_comb begin
    xf_data = head;
    xf_lf   = 1'b0;
    if (DATA_W == 8) begin
      if (mode == MODE_UPPER && head >= DATA_W'(ASCII_LC_A) && head <= DATA_W'(ASCII_LC_Z))
        xf_data = head - DATA_W'(CASE_OFS);
      if (mode == MODE_CRLF && head == DATA_W'(ASCII_CR))
        xf_lf = 1'b1;
    end
  end

  always_comb begin
    state_nx      = state;
    tx_data_nx    = tx_data;
    tx_valid_nx   = 1'b0;
    pending_lf_nx = pending_lf;
    case (state)
      ST_IDLE: begin
        if (pop && mode != MODE_SINK) begin
          tx_data_nx    = xf_data;
          tx_valid_nx   = 1'b1;
          pending_lf_nx = xf_lf;
          state_nx      = ST_LAUNCH;
        end
      end
      ST_LAUNCH:    state_nx = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy) state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (pending_lf) begin
            pending_lf_nx = 1'b0;
            tx_data_nx    = DATA_W'(ASCII_LF);
            tx_valid_nx   = 1'b1;
            state_nx      = ST_LAUNCH;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      pending_lf <= 1'b0;
    end else begin
      state      <= state_nx;
      tx_data    <= tx_data_nx;
      tx_valid   <= tx_valid_nx;
      pending_lf <= pending_lf_nx;
    end
  end

  // A clear coinciding with a drop still counts that drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led      <= '1;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (rx_valid) led <= ~rx_data[LED_W-1:0];
      if (clr_status) begin
        overflow <= 1'b0;
        drop_cnt <= drop ? CNT_W'(1) : '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_engine.sv
// Randomized self-checking bench for uart_echo_engine with a queue-based reference model.
module tb_uart_echo_engine;

  localparam int BUSY_LEN = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       clr_status = 1'b0;
  logic [5:0] led;
  logic [4:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int  busy_cnt = 0;
  bit  busy_hold = 0;
  bit  busy_block = 0;
  bit  prev_valid = 0;
  int  wide_cnt = 0;

  uart_echo_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_busy    (tx_busy),
    .mode       (mode),
    .clr_status (clr_status),
    .led        (led),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: captures launches and holds busy for BUSY_LEN cycles.
  always @(negedge clk) begin
    if (tx_valid) begin
      got_q.push_back(tx_data);
      if (prev_valid) wide_cnt++;
      if (!busy_block) busy_cnt = BUSY_LEN;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_valid = tx_valid;
    tx_busy = busy_hold || (busy_cnt > 0);
  end

  function automatic void model_push(input logic [7:0] b, input logic [1:0] m);
    case (m)
      2'b00: exp_q.push_back(b);
      2'b01: exp_q.push_back((b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b);
      2'b10: begin
        exp_q.push_back(b);
        if (b == 8'h0D) exp_q.push_back(8'h0A);
      end
      default: ;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 5 && n < budget) begin
      @(negedge clk);
      n++;
      if (tx_valid || tx_busy || fifo_level != 0) quiet = 0;
      else quiet++;
    end
    checks++;
    if (quiet < 5) begin
      errors++;
      $display("FAIL %s: timeout waiting for idle after %0d cycles", name, n);
    end
  endtask

  task automatic check_stream(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s: stream length %0d, expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s[%0d]: tx_data %02h, expected %02h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (wide_cnt !== 0) begin
      errors++;
      $display("FAIL %s: tx_valid wider than one cycle %0d times, expected 0", name, wide_cnt);
    end
    got_q.delete();
    exp_q.delete();
    wide_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || led !== 6'h3F || fifo_level !== 5'd0 ||
        overflow !== 1'b0 || drop_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset: v=%b d=%02h led=%02h lvl=%0d ovf=%b drop=%0d, expected 0 00 3f 0 0 0",
               tx_valid, tx_data, led, fifo_level, overflow, drop_cnt);
    end
    got_q.delete();
  endtask

  task automatic test_echo();
    logic [7:0] b;
    mode = 2'b00;
    send_byte(8'h41);
    model_push(8'h41, mode);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      errors++;
      $display("FAIL echo_latency: tx_valid=%b tx_data=%02h, expected 1 41", tx_valid, tx_data);
    end
    repeat (100) @(negedge clk);
    send_byte(8'h42); model_push(8'h42, mode);
    repeat (100) @(negedge clk);
    send_byte(8'h43); model_push(8'h43, mode);
    wait_idle("echo", 2000);
    checks++;
    if (led !== 6'h3C) begin
      errors++;
      $display("FAIL echo_led: led=%02h, expected 3c", led);
    end
    check_stream("echo_fixed");
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b);
      model_push(b, mode);
    end
    wait_idle("echo_rand", 2000);
    check_stream("echo_rand");
  endtask

  task automatic test_upper();
    logic [7:0] b;
    mode = 2'b01;
    send_byte(8'h61); model_push(8'h61, mode);
    send_byte(8'h5A); model_push(8'h5A, mode);
    send_byte(8'h7B); model_push(8'h7B, mode);
    for (int i = 0; i < 12; i++) begin
      b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h60, 8'h7B)) : 8'($urandom_range(0, 255));
      send_byte(b);
      model_push(b, mode);
    end
    wait_idle("upper", 3000);
    check_stream("upper");
  endtask

  task automatic test_crlf();
    int n;
    mode = 2'b10;
    send_byte(8'h48); model_push(8'h48, mode);
    send_byte(8'h0D); model_push(8'h0D, mode);
    send_byte(8'h49); model_push(8'h49, mode);
    wait_idle("crlf", 2000);
    check_stream("crlf_fixed");
    send_byte(8'h0D); model_push(8'h0D, 2'b10);
    n = 0;
    while (got_q.size() < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    mode = 2'b00;
    send_byte(8'h0D); model_push(8'h0D, 2'b00);
    send_byte(8'h61); model_push(8'h61, 2'b00);
    wait_idle("crlf_switch", 2000);
    check_stream("crlf_switch");
  endtask

  task automatic test_random_modes();
    logic [7:0] b;
    int r;
    for (int round = 0; round < 6; round++) begin
      mode = 2'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 3);
        b = (r == 0) ? 8'h0D : (r == 1) ? 8'($urandom_range(8'h61, 8'h7A)) : 8'($urandom_range(0, 255));
        send_byte(b);
        model_push(b, mode);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle("rand_modes", 4000);
      check_stream("rand_modes");
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    mode = 2'b00;
    busy_hold = 1;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b);
      if (i < 16) model_push(b, mode);
    end
    checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 8'd4) begin
      errors++;
      $display("FAIL overflow: lvl=%0d ovf=%b drop=%0d, expected 16 1 4", fifo_level, overflow, drop_cnt);
    end
    checks++;
    if (led !== ~b[5:0]) begin
      errors++;
      $display("FAIL overflow_led: led=%02h, expected %02h", led, ~b[5:0]);
    end
    busy_hold = 0;
    wait_idle("overflow_drain", 5000);
    check_stream("overflow_drain");
    busy_hold = 1;
    for (int i = 0; i < 316; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b);
      if (i < 16) model_push(b, mode);
    end
    checks++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drop_sat: drop=%0d ovf=%b, expected 255 1", drop_cnt, overflow);
    end
    clr_status = 1'b1;
    send_byte(8'h77);
    clr_status = 1'b0;
    checks++;
    if (drop_cnt !== 8'd1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_with_drop: drop=%0d ovf=%b, expected 1 0", drop_cnt, overflow);
    end
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr: drop=%0d ovf=%b, expected 0 0", drop_cnt, overflow);
    end
    busy_hold = 0;
    wait_idle("refill_drain", 5000);
    check_stream("refill_drain");
  endtask

  task automatic test_sink();
    mode = 2'b11;
    for (int i = 0; i < 10; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      @(negedge clk);
      checks++;
      if (fifo_level !== 5'd0) begin
        errors++;
        $display("FAIL sink_level[%0d]: lvl=%0d, expected 0", i, fifo_level);
      end
      repeat (2) @(negedge clk);
    end
    check_stream("sink");
  endtask

  task automatic test_reset_midflight();
    mode = 2'b00;
    busy_block = 1;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)));
    checks++;
    if (fifo_level !== 5'd5) begin
      errors++;
      $display("FAIL midflight_queued: lvl=%0d, expected 5", fifo_level);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (fifo_level !== 5'd0 || tx_valid !== 1'b0 || led !== 6'h3F) begin
      errors++;
      $display("FAIL midflight_reset: lvl=%0d v=%b led=%02h, expected 0 0 3f", fifo_level, tx_valid, led);
    end
    got_q.delete();
    wide_cnt = 0;
    busy_block = 0;
    repeat (30) @(negedge clk);
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL midflight_quiet: %0d launches after reset, expected 0", got_q.size());
    end
    send_byte(8'h55);
    model_push(8'h55, mode);
    wait_idle("midflight_echo", 2000);
    check_stream("midflight_echo");
  endtask

  initial begin
    test_reset();
    test_echo();
    test_upper();
    test_crlf();
    test_random_modes();
    test_overflow();
    test_sink();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
